// File: rtl/pe_mac_accum.sv
// pe_mac_accum: MAC processing element writing saturated partial sums.
// Ports: clk, rst (async low), start/cfg_*, in_valid/in_ready/ifmap/weight,
//        psum_wr/psum_addr/psum_data, busy, done.
module pe_mac_accum #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               cfg_len,
  input  logic [2:0]               cfg_shift,
  input  logic [ADDR_W-1:0]        cfg_num,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] ifmap,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     psum_wr,
  output logic [ADDR_W-1:0]        psum_addr,
  output logic [DATA_W-1:0]        psum_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t                   r_state;
  logic [3:0]               r_len;
  logic [2:0]               r_shift;
  logic [ADDR_W-1:0]        r_num;
  logic signed [ACC_W-1:0]  r_acc;
  logic [4:0]               r_term;
  logic [ADDR_W:0]          r_cnt;

  logic                     w_fire;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [DATA_W-1:0]        w_sat;
  logic [4:0]               w_len_full;
  logic [ADDR_W:0]          w_num_full;
  logic [4:0]               w_term_nxt;
  logic [ADDR_W:0]          w_cnt_nxt;
  logic                     w_last_term;
  logic                     w_last_psum;

  assign w_fire     = in_valid & in_ready;
  assign w_prod     = ifmap * weight;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_nxt  = r_acc + w_prod_ext;
  assign w_shifted  = w_acc_nxt >>> r_shift;

  // Zero encodes the maximum count for both length and job size.
  assign w_len_full = (r_len == 4'd0) ? 5'd16 : {1'b0, r_len};
  assign w_num_full = (r_num == '0) ?
    {1'b1, {ADDR_W{1'b0}}} : {1'b0, r_num};

  assign w_term_nxt  = r_term + 5'd1;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last_term = (w_term_nxt == w_len_full);
  assign w_last_psum = (w_cnt_nxt == w_num_full);

  always_comb begin
    w_sat = w_shifted[DATA_W-1:0];
    unique case (1'b1)
      (w_shifted > SAT_MAX): w_sat = SAT_MAX[DATA_W-1:0];
      (w_shifted < SAT_MIN): w_sat = SAT_MIN[DATA_W-1:0];
      default:               w_sat = w_shifted[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_shift   <= '0;
      r_num     <= '0;
      r_acc     <= '0;
      r_term    <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b0;
      psum_wr   <= 1'b0;
      psum_addr <= '0;
      psum_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_len     <= cfg_len;
            r_shift   <= cfg_shift;
            r_num     <= cfg_num;
            r_acc     <= '0;
            r_term    <= '0;
            r_cnt     <= '0;
            psum_addr <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_fire) begin
            r_acc  <= w_acc_nxt;
            r_term <= w_term_nxt;
            // Final term: result is formed from the updated sum now
            // so the write strobe appears one cycle after the edge.
            if (w_last_term) begin
              in_ready  <= 1'b0;
              psum_wr   <= 1'b1;
              psum_data <= w_sat;
              r_state   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          psum_wr   <= 1'b0;
          r_acc     <= '0;
          r_term    <= '0;
          psum_addr <= psum_addr + 1'b1;
          r_cnt     <= w_cnt_nxt;
          if (w_last_psum) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            r_state  <= S_ACCUM;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_accum.sv
// tb_pe_mac_accum: directed self-checking bench for pe_mac_accum.
// Drives at negedge, samples at negedge; writes logged by a monitor.
module tb_pe_mac_accum;

  localparam int DW = 8;
  localparam int AW = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [3:0]           cfg_len = '0;
  logic [2:0]           cfg_shift = '0;
  logic [AW-1:0]        cfg_num = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] ifmap = '0;
  logic signed [DW-1:0] weight = '0;
  logic                 psum_wr;
  logic [AW-1:0]        psum_addr;
  logic [DW-1:0]        psum_data;
  logic                 busy;
  logic                 done;

  pe_mac_accum #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_num   (cfg_num),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifmap     (ifmap),
    .weight    (weight),
    .psum_wr   (psum_wr),
    .psum_addr (psum_addr),
    .psum_data (psum_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int done_cnt = 0;
  int ready_bad = 0;

  always @(negedge clk) begin
    if (psum_wr) begin
      wq_addr.push_back(psum_addr);
      wq_data.push_back(psum_data);
    end
    if (done) done_cnt++;
    if (psum_wr && in_ready) ready_bad++;
    if (busy && !psum_wr && !done && !in_ready) ready_bad++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  task automatic chk_wr(input int idx,
                        input logic [31:0] a,
                        input logic [31:0] d);
    if (idx < wq_addr.size()) begin
      chk("wr_addr", 32'(wq_addr[idx]), a);
      chk("wr_data", 32'(wq_data[idx]), d);
    end else begin
      chk("wr_missing", 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic start_job(input logic [3:0] l,
                           input logic [2:0] s,
                           input logic [AW-1:0] n);
    @(negedge clk);
    cfg_len = l;
    cfg_shift = s;
    cfg_num = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
    ready_bad = 0;
  endtask

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    ifmap = 8'(a);
    weight = 8'(b);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int exp4[4];
    int a;
    int b;

    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr", 32'(psum_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(psum_addr), 0);
    chk("rst_data", 32'(psum_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic two-term sum and write latency.
    start_job(4'd2, 3'd0, 6'd1);
    chk("t1_busy", 32'(busy), 1);
    send(3, 4);
    send(5, -2);
    in_valid = 1'b0;
    chk("t1_wr", 32'(psum_wr), 1);
    chk("t1_addr", 32'(psum_addr), 0);
    chk("t1_data", 32'(psum_data), 32'h02);
    chk("t1_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_wr_off", 32'(psum_wr), 0);
    chk("t1_hold", 32'(psum_data), 32'h02);
    @(negedge clk);
    chk("t1_busy_lo", 32'(busy), 0);
    chk("t1_done_lo", 32'(done), 0);
    chk("t1_addr_nx", 32'(psum_addr), 1);

    // Saturation both directions.
    start_job(4'd4, 3'd0, 6'd2);
    repeat (4) send(127, 127);
    repeat (4) send(-128, 127);
    in_valid = 1'b0;
    wait_idle();
    chk("t2_n", 32'(wq_addr.size()), 2);
    chk_wr(0, 0, 32'h7f);
    chk_wr(1, 1, 32'h80);
    chk("t2_done", 32'(done_cnt), 1);

    // Arithmetic shift positive and negative.
    start_job(4'd1, 3'd2, 6'd1);
    send(100, 3);
    in_valid = 1'b0;
    wait_idle();
    chk_wr(0, 0, 32'h4b);
    start_job(4'd1, 3'd2, 6'd1);
    send(-100, 3);
    in_valid = 1'b0;
    wait_idle();
    chk_wr(0, 0, 32'hb5);

    // Continuous valid across write cycles.
    for (int g = 0; g < 4; g++) exp4[g] = 0;
    start_job(4'd3, 3'd0, 6'd4);
    for (int i = 0; i < 12; i++) begin
      a = i * 7 - 40;
      b = 13 - i * 3;
      exp4[i / 3] += a * b;
      send(a, b);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("t4_n", 32'(wq_addr.size()), 4);
    for (int g = 0; g < 4; g++)
      chk_wr(g, 32'(g), 32'(sat8(exp4[g])));
    chk("t4_ready", 32'(ready_bad), 0);
    chk("t4_done", 32'(done_cnt), 1);

    // Full-size job: 64 sums of 16 terms, address wraps.
    start_job(4'd0, 3'd0, 6'd0);
    for (int p = 0; p < 64; p++)
      for (int t = 0; t < 16; t++)
        send((p % 16) - 8, 1);
    in_valid = 1'b0;
    wait_idle();
    chk("t5_n", 32'(wq_addr.size()), 64);
    for (int p = 0; p < 64; p++)
      chk_wr(p, 32'(p), 32'(sat8(16 * ((p % 16) - 8))));
    chk("t5_done", 32'(done_cnt), 1);
    chk("t5_addr", 32'(psum_addr), 0);

    // Reset mid-accumulation, then a fresh job.
    start_job(4'd3, 3'd0, 6'd2);
    send(1, 1);
    send(2, 2);
    send(3, 3);
    send(5, 5);
    send(6, 6);
    in_valid = 1'b0;
    chk("t6_pre_addr", 32'(psum_addr), 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_ready", 32'(in_ready), 0);
    chk("t6_wr", 32'(psum_wr), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_addr", 32'(psum_addr), 0);
    chk("t6_data", 32'(psum_data), 0);
    @(negedge clk);
    rst = 1'b1;
    chk("t6_nwr", 32'(wq_addr.size()), 1);
    chk_wr(0, 0, 32'h0e);
    start_job(4'd2, 3'd0, 6'd1);
    send(10, 10);
    send(2, 3);
    in_valid = 1'b0;
    wait_idle();
    chk("t6_n", 32'(wq_addr.size()), 1);
    chk_wr(0, 0, 32'h6a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mac_accum.md
PE_MAC_ACCUM -- requirements
Module: pe_mac_accum

Interface
REQ-001 Parameter DATA_W, default 8, operand and partial-sum width.
REQ-002 Parameter ADDR_W, default 6, partial-sum scratchpad address width (64 entries).
REQ-003 Parameter ACC_W, default 20, internal signed accumulator width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; latches config and begins a job; ignored unless IDLE.
REQ-007 cfg_len  input  4  products per partial sum; 0 means 16.
REQ-008 cfg_shift  input  3  arithmetic right-shift applied before saturation.
REQ-009 cfg_num  input  ADDR_W  partial sums per job; 0 means 64.
REQ-010 in_valid  input  1  ifmap/weight pair valid.
REQ-011 in_ready  output  1  block accepts pair this cycle.
REQ-012 ifmap, weight  input  DATA_W each  signed two's-complement operands.
REQ-013 psum_wr  output  1  one-cycle write strobe to the partial-sum scratchpad.
REQ-014 psum_addr  output  ADDR_W  write address.
REQ-015 psum_data  output  DATA_W  signed saturated partial sum.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse at end of job.

Function
REQ-018 States: IDLE, ACCUM, WRITE, DONE; all outputs registered.
REQ-019 IDLE -> ACCUM on start; latch cfg_len, cfg_shift, cfg_num; clear accumulator, term counter, psum counter, address to 0.
REQ-020 in_ready = 1 only in ACCUM; transfer occurs on an edge with in_valid and in_ready both high.
REQ-021 Each transfer: acc <= acc + sign-extended (ifmap*weight) (16-bit signed product); term counter increments.
REQ-022 Transfer of term number len (1..16) -> WRITE at same edge, acc holds final sum.
REQ-023 In WRITE (exactly one cycle): psum_wr=1, psum_addr=current address, psum_data=sat8(acc >>> shift); latency last transfer edge to psum_wr high = 1 cycle.
REQ-024 Saturation: result > 127 -> 127; < -128 -> -128; otherwise low DATA_W bits.
REQ-025 Leaving WRITE: clear acc and term counter, address+1 (wraps 63->0), psum counter+1; if psum count reaches num -> DONE, else ACCUM.
REQ-026 DONE (one cycle): done=1, then IDLE; address register retains last value+1 modulo 64.
REQ-027 psum_data holds its last value when psum_wr=0; psum_wr never asserted outside WRITE.
REQ-028 start while busy is ignored; in_valid while not in ACCUM is not consumed.
REQ-029 No overflow handling beyond ACC_W: 16*(-128*-128)=262144 fits in 20 bits signed.

Reset
REQ-030 rst low asynchronously forces IDLE; in_ready, psum_wr, busy, done = 0; psum_addr, psum_data, acc, counters, latched config = 0.
REQ-031 Reset asserted mid-job abandons the job with no write; first job after release starts at address 0.

Verification
REQ-032 len=2, shift=0, num=1; pairs (3,4),(5,-2) -> psum_wr one cycle after 2nd transfer, addr 0, data 2; done next cycle; busy low after.
REQ-033 len=4, num=2; four (127,127) then four (-128,127) -> data 127 at addr 0, -128 at addr 1.
REQ-034 len=1, shift=2; pair (100,3) -> data 75 (300>>>2); pair (-100,3) with shift=2 -> -75.
REQ-035 len=3, in_valid held high continuously -> in_ready low exactly in WRITE cycles; no pair dropped/duplicated against reference model.
REQ-036 cfg_num=0, cfg_len=0 -> 64 writes, addr 0..63, each after 16 terms; done once after addr 63 write.
REQ-037 rst pulsed low during ACCUM after 2 terms -> all outputs 0 immediately; new job writes addr 0 with correct sum.
